// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;
    localparam int          INST_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_RESET,
        FS_RUN,
        FS_FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {inst, pc} entries between imem response and decode.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is ignored when full unless a pop frees a slot that cycle; flush wins over push.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int Q_DEPTH = 2,
    parameter int CNT_W   = $clog2(Q_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     pushData,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     headData,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

    fetch_entry_t     mem [Q_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign doPop    = pop && (count != '0);
    assign doPush   = push && ((count != CNT_W'(Q_DEPTH)) || doPop);
    assign headData = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= bump(wrPtr);
            if (doPop)  rdPtr <= bump(rdPtr);
            if (doPush && !doPop)      count <= count + CNT_W'(1);
            else if (!doPush && doPop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushData;
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// PC owner and imem read driver feeding decode over valid/ready; FETCH_MISALIGN_TRAP_EN enables misaligned-redirect trap.
// Latency: first request one cycle after reset release, first out_valid two cycles after that.
// Backpressure: fetch stalls when queued plus in-flight entries would exceed Q_DEPTH; outputs held while !out_ready.
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter int          INST_DEPTH = 1024,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          Q_DEPTH    = 2,
    parameter int          IDX_W      = $clog2(INST_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [IDX_W-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc_plus4,
    output logic             fault
);
    localparam int CNT_W = $clog2(Q_DEPTH + 1);

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [31:0]      reqPc;
    logic [31:0]      redirectTarget;
    logic             pending;
    logic             epoch;
    logic             reqEpoch;
    logic             running;
    logic             issue;
    logic             flush;
    logic             popFire;
    logic             pushFire;
    logic             badRedirect;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     respEntry;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign badRedirect    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirectTarget = redirect_pc;
    assign fault          = (state == FS_FAULT);
`else
    logic unusedPcLsbs;
    assign unusedPcLsbs   = ^redirect_pc[1:0];
    assign badRedirect    = 1'b0;
    assign redirectTarget = {redirect_pc[31:2], 2'b00};
    assign fault          = 1'b0;
`endif

    assign running = (state == FS_RUN);
    assign popFire = out_valid && out_ready;
    // Credit the entry leaving this cycle so a steady stream keeps one fetch per cycle.
    assign issue   = running && !redirect_valid &&
                     ((int'(count) + int'(pending) - int'(popFire)) < Q_DEPTH);
    assign flush   = (running && redirect_valid) || (state == FS_FAULT);

    // A response tagged with an older epoch belongs to the wrong path.
    assign pushFire  = pending && (reqEpoch == epoch);
    assign respEntry = '{inst: imem_rdata, pc: reqPc};

    fetch_queue #(
        .Q_DEPTH (Q_DEPTH),
        .CNT_W   (CNT_W)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (pushFire),
        .pushData (respEntry),
        .pop      (popFire),
        .flush    (flush),
        .headData (head),
        .count    (count)
    );

    assign imem_req     = issue;
    assign imem_addr    = pc[IDX_W+1:2];
    assign out_valid    = (count != '0);
    assign out_inst     = out_valid ? head.inst : '0;
    assign out_pc       = out_valid ? head.pc : '0;
    assign out_pc_plus4 = out_valid ? head.pc + 32'd4 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FS_RESET;
            pc       <= RESET_PC;
            reqPc    <= '0;
            pending  <= 1'b0;
            epoch    <= 1'b0;
            reqEpoch <= 1'b0;
        end else begin
            case (state)
                FS_RESET: state <= FS_RUN;
                FS_RUN: begin
                    pending <= issue;
                    if (issue) begin
                        reqPc    <= pc;
                        reqEpoch <= epoch;
                        pc       <= pc + 32'd4;
                    end
                    if (redirect_valid) begin
                        epoch <= ~epoch;
                        pc    <= redirectTarget;
                        if (badRedirect) state <= FS_FAULT;
                    end
                end
                FS_FAULT: pending <= 1'b0;
                default:  state <= FS_RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: expected entries queued by stimulus, compared by a negedge monitor.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] plus4;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycNow;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .INST_DEPTH (1024),
        .RESET_PC   (32'h0),
        .Q_DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fault          (fault)
    );

    // Synchronous ROM: word k holds 32'h1000_0000 + k.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h1000_0000 + {22'd0, imem_addr};
    end

    // Cycle 0 is the first cycle in which the fetch unit is running.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycNow <= -1;
        else        cycNow <= cycNow + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic pushExp(input logic [31:0] word, input logic [31:0] pc,
                           input logic [31:0] plus4, input int cyc);
        exp_t e;
        e.inst  = 32'h1000_0000 + word;
        e.pc    = pc;
        e.plus4 = plus4;
        e.cyc   = cyc;
        expQ.push_back(e);
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic waitAccepts(input int n, input string name);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 60) begin
            @(negedge clk);
            if (out_valid && out_ready) got++;
            nextCycle();
            budget++;
        end
        if (got < n) begin
            compared++;
            mismatched++;
            $display("FAIL %s: accepted %0d, want %0d", name, got, n);
        end
    endtask

    // Monitor: every accepted output must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: got pc %h, want no output", out_pc);
                end else begin
                    e = expQ.pop_front();
                    check("out_inst", out_inst, e.inst);
                    check("out_pc", out_pc, e.pc);
                    check("out_pc_plus4", out_pc_plus4, e.plus4);
                    if (e.cyc >= 0) check("out_cycle", cycNow, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) nextCycle();

        // Reset state
        @(negedge clk);
        check("rst_imem_req", imem_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_pc_plus4", out_pc_plus4, 0);
        check("rst_fault", fault, 0);
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("release_no_req", imem_req, 0);
        nextCycle();
        @(negedge clk);
        check("cyc0_req", imem_req, 1);
        check("cyc0_addr", imem_addr, 0);
        nextCycle();

        // Streaming at full rate: word k at cycle 2+k
        for (int k = 0; k < 6; k++) pushExp(k, 4 * k, 4 * k + 4, 2 + k);
        waitAccepts(6, "stream");

        // Decode stall: head held, fetch stops
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_pc", out_pc, 32'd24);
            check("stall_inst", out_inst, 32'h1000_0006);
            check("stall_req", imem_req, 0);
            nextCycle();
        end
        for (int k = 6; k < 10; k++) pushExp(k, 4 * k, 4 * k + 4, -1);
        out_ready = 1'b1;
        waitAccepts(4, "stall_drain");

        // Redirect with queued entry and a request in flight
        out_ready = 1'b0;
        repeat (4) nextCycle();
        @(negedge clk);
        check("full_head_pc", out_pc, 32'd40);
        check("full_no_req", imem_req, 0);
        nextCycle();
        pushExp(10, 32'd40, 32'd44, -1);
        out_ready = 1'b1;
        waitAccepts(1, "pre_redirect_pop");
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        check("redirect_no_req", imem_req, 0);
        nextCycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_req", imem_req, 1);
        check("redir_addr", imem_addr, 16);
        check("redir_flushed", out_valid, 0);
        nextCycle();
        @(negedge clk);
        check("redir_stale_dropped", out_valid, 0);
        check("redir_addr2", imem_addr, 17);
        nextCycle();
        @(negedge clk);
        check("redir_valid", out_valid, 1);
        check("redir_pc", out_pc, 32'h40);
        nextCycle();
        nextCycle();

        // Redirect coincident with a pop
        pushExp(16, 32'h40, 32'h44, -1);
        pushExp(17, 32'h44, 32'h48, -1);
        out_ready = 1'b1;
        waitAccepts(1, "pop_before_redirect");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        check("coincident_pc", out_pc, 32'h44);
        nextCycle();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        @(negedge clk);
        check("coinc_req", imem_req, 1);
        check("coinc_addr", imem_addr, 64);
        check("coinc_flushed", out_valid, 0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        check("coinc_target_pc", out_pc, 32'h100);
        nextCycle();
        pushExp(64, 32'h100, 32'h104, -1);
        pushExp(65, 32'h104, 32'h108, -1);
        out_ready = 1'b1;
        waitAccepts(2, "coinc_drain");

        // PC and imem address wrap
        out_ready = 1'b0;
        repeat (4) nextCycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        nextCycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr", imem_addr, 10'h3FE);
        nextCycle();
        pushExp(32'h3FE, 32'hFFFF_FFF8, 32'hFFFF_FFFC, -1);
        pushExp(32'h3FF, 32'hFFFF_FFFC, 32'h0000_0000, -1);
        pushExp(0, 32'h0000_0000, 32'h0000_0004, -1);
        pushExp(1, 32'h0000_0004, 32'h0000_0008, -1);
        out_ready = 1'b1;
        waitAccepts(4, "wrap_drain");

        // Misaligned redirect target
        out_ready = 1'b0;
        repeat (4) nextCycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        nextCycle();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("trap_fault", fault, 1);
            check("trap_no_req", imem_req, 0);
            check("trap_no_valid", out_valid, 0);
            nextCycle();
        end
`else
        @(negedge clk);
        check("align_req", imem_req, 1);
        check("align_addr", imem_addr, 16);
        check("align_fault", fault, 0);
        nextCycle();
        pushExp(16, 32'h40, 32'h44, -1);
        pushExp(17, 32'h44, 32'h48, -1);
        out_ready = 1'b1;
        waitAccepts(2, "align_drain");
`endif

        // Reset mid-operation discards everything
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_req", imem_req, 0);
        check("midrst_fault", fault, 0);
        check("midrst_pc", out_pc, 0);
        nextCycle();
        nextCycle();
        out_ready = 1'b1;
        rst_n     = 1'b1;
        pushExp(0, 32'h0, 32'h4, 2);
        pushExp(1, 32'h4, 32'h8, 3);
        waitAccepts(2, "post_reset");
        out_ready = 1'b0;
        nextCycle();

        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_expected: got %0d pending, want 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
